// File: rtl/alu_issue_queue_if.sv
// Command/result/ALU signal bundle for alu_issue_queue.
//   in_*   : command channel (valid/ready, op code, operands A/B)
//   alu_*  : FIFO head presented to the external combinational ALU, and its result
//   out_*  : registered result channel (valid/ready, data, op code, zero flag)
// slave modport is the queue side; master modport is the producer/consumer/ALU side.
interface alu_issue_queue_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_sel;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_out;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_sel;
  logic             out_zero;

  modport slave (
    input  in_valid, in_sel, in_a, in_b, alu_out, out_ready,
    output in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_sel, out_zero
  );

  modport master (
    output in_valid, in_sel, in_a, in_b, alu_out, out_ready,
    input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_data, out_sel, out_zero
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Issue queue in front of a 32-bit combinational ALU: buffers commands in a
// DEPTH-entry FIFO, presents the head to the ALU and registers the result.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : alu_issue_queue_if.slave (command in, ALU head/result, result out)
//   level  : FIFO occupancy 0..DEPTH
module alu_issue_queue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_queue_if.slave  bus,
  output logic [LVL_W-1:0]  level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_a   [DEPTH];
  logic [WIDTH-1:0] mem_b   [DEPTH];
  logic [2:0]       mem_sel [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] count;

  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [2:0]       out_sel_q;
  logic             out_zero_q;

  logic empty_c;
  logic full_c;
  logic push_c;
  logic pop_c;

  // Handshake decode; a full queue refuses pushes even when popping this cycle.
  assign empty_c = (count == '0);
  assign full_c  = (count == LVL_W'(DEPTH));
  assign push_c  = bus.in_valid && !full_c;
  assign pop_c   = !empty_c && (!out_valid_q || bus.out_ready);

  assign bus.in_ready = !full_c;

  // Head goes to the ALU; zeros when empty so the ALU sees a quiet input.
  assign bus.alu_a   = empty_c ? '0 : mem_a[rd_ptr];
  assign bus.alu_b   = empty_c ? '0 : mem_b[rd_ptr];
  assign bus.alu_sel = empty_c ? '0 : mem_sel[rd_ptr];

  // Command storage, no reset needed: entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_a[wr_ptr]   <= bus.in_a;
      mem_b[wr_ptr]   <= bus.in_b;
      mem_sel[wr_ptr] <= bus.in_sel;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); count disambiguates full/empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Result register: load on pop, drop valid when consumed with nothing new behind it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_zero_q  <= 1'b0;
    end else if (pop_c) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.alu_out;
      out_sel_q   <= mem_sel[rd_ptr];
      out_zero_q  <= (bus.alu_out == '0);
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_zero  = out_zero_q;
  assign level         = count;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural ALU on the alu_* side.
module tb_alu_issue_queue;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] level;

  int passed = 0;
  int total  = 0;

  alu_issue_queue_if #(.WIDTH(32)) bus ();

  alu_issue_queue #(.WIDTH(32), .DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .level (level)
  );

  always #5 clk = ~clk;

  // Reference ALU: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 not A, 110 shl, 111 shr.
  always_comb begin
    case (bus.alu_sel)
      3'b000:  bus.alu_out = bus.alu_a + bus.alu_b;
      3'b001:  bus.alu_out = bus.alu_a - bus.alu_b;
      3'b010:  bus.alu_out = bus.alu_a & bus.alu_b;
      3'b011:  bus.alu_out = bus.alu_a | bus.alu_b;
      3'b100:  bus.alu_out = bus.alu_a ^ bus.alu_b;
      3'b101:  bus.alu_out = ~bus.alu_a;
      3'b110:  bus.alu_out = bus.alu_a << bus.alu_b[4:0];
      default: bus.alu_out = bus.alu_a >> bus.alu_b[4:0];
    endcase
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid = 1'b1;
    bus.in_sel   = sel;
    bus.in_a     = a;
    bus.in_b     = b;
  endtask

  logic [31:0] exp4 [6];
  int          k;
  logic        accept;

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sel    = 3'b000;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;

    // 1: reset
    cyc();
    cyc();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_level",     32'(level),         32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_alu_a",     bus.alu_a,          32'd0);
    chk("rst_alu_sel",   32'(bus.alu_sel),   32'd0);
    rst_n = 1'b1;
    cyc();
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

    // 2: single add, result visible after the second edge
    drive(3'b000, 32'd5, 32'd7);
    cyc();
    bus.in_valid = 1'b0;
    chk("add_level_after_push", 32'(level),         32'd1);
    chk("add_head_a",           bus.alu_a,          32'd5);
    chk("add_not_yet_valid",    32'(bus.out_valid), 32'd0);
    cyc();
    chk("add_out_valid", 32'(bus.out_valid), 32'd1);
    chk("add_out_data",  bus.out_data,       32'd12);
    chk("add_out_sel",   32'(bus.out_sel),   32'd0);
    chk("add_out_zero",  32'(bus.out_zero),  32'd0);
    chk("add_level_0",   32'(level),         32'd0);
    bus.out_ready = 1'b1;
    cyc();
    chk("add_consumed",  32'(bus.out_valid), 32'd0);
    chk("add_data_held", bus.out_data,       32'd12);

    // 3: stream of 8 subtracts, one result per cycle
    for (int i = 0; i < 8; i++) begin
      drive(3'b001, 32'(i), 32'(i));
      cyc();
      if (i > 0) begin
        chk("stream_valid", 32'(bus.out_valid), 32'd1);
        chk("stream_data",  bus.out_data,       32'd0);
        chk("stream_zero",  32'(bus.out_zero),  32'd1);
        chk("stream_level", 32'(level),         32'd1);
      end
    end
    bus.in_valid = 1'b0;
    cyc();
    chk("stream_last_valid", 32'(bus.out_valid), 32'd1);
    chk("stream_last_zero",  32'(bus.out_zero),  32'd1);
    chk("stream_last_sel",   32'(bus.out_sel),   32'd1);
    chk("stream_drained",    32'(level),         32'd0);
    cyc();
    chk("stream_idle", 32'(bus.out_valid), 32'd0);

    // 4: backpressure, 6 commands with the consumer stalled
    for (int i = 0; i < 6; i++) exp4[i] = 32'(i * 10 + 1);
    bus.out_ready = 1'b0;
    k = 0;
    for (int t = 0; t < 20 && k < 5; t++) begin
      drive(3'b000, 32'(k * 10), 32'd1);
      accept = bus.in_ready;
      cyc();
      if (accept) k++;
    end
    drive(3'b000, 32'd50, 32'd1);
    cyc();
    cyc();
    chk("bp_level_full", 32'(level),         32'd4);
    chk("bp_in_ready",   32'(bus.in_ready),  32'd0);
    chk("bp_out_valid",  32'(bus.out_valid), 32'd1);
    chk("bp_held_data",  bus.out_data,       32'd1);
    bus.out_ready = 1'b1;
    k = 0;
    for (int t = 0; t < 20 && k < 6; t++) begin
      if (bus.out_valid) begin
        chk("bp_order", bus.out_data, exp4[k]);
        k++;
      end
      accept = bus.in_valid && bus.in_ready;
      cyc();
      if (accept) bus.in_valid = 1'b0;
    end
    chk("bp_result_count", 32'(k),            32'd6);
    chk("bp_end_valid",    32'(bus.out_valid), 32'd0);
    chk("bp_end_level",    32'(level),         32'd0);

    // 5: pointer wrap, 3 rounds of DEPTH commands
    for (int r = 0; r < 3; r++) begin
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        drive(3'b110, 32'h8000_0001, 32'd1);
        cyc();
      end
      bus.in_valid = 1'b0;
      chk("wrap_level", 32'(level), 32'd3);
      bus.out_ready = 1'b1;
      k = 0;
      for (int t = 0; t < 10 && k < 4; t++) begin
        if (bus.out_valid) begin
          chk("wrap_data", bus.out_data, 32'h0000_0002);
          k++;
        end
        cyc();
      end
      chk("wrap_count", 32'(k), 32'd4);
    end
    chk("wrap_sel_last", 32'(bus.out_sel), 32'd6);

    // 6: reset with level=3 and a held result
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(3'b000, 32'(i + 1), 32'(i + 1));
      cyc();
    end
    bus.in_valid = 1'b0;
    chk("mid_level",     32'(level),         32'd3);
    chk("mid_out_valid", 32'(bus.out_valid), 32'd1);
    chk("mid_out_data",  bus.out_data,       32'd2);
    rst_n = 1'b0;
    cyc();
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_level",     32'(level),         32'd0);
    chk("mrst_out_data",  bus.out_data,       32'd0);
    chk("mrst_alu_a",     bus.alu_a,          32'd0);
    rst_n = 1'b1;
    cyc();
    chk("mrst_no_stale", 32'(bus.out_valid), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready),  32'd1);
    drive(3'b000, 32'd0, 32'd0);
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    chk("fresh_valid", 32'(bus.out_valid), 32'd1);
    chk("fresh_zero",  32'(bus.out_zero),  32'd1);
    chk("fresh_level", 32'(level),         32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
